// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage owning the PC, one outstanding imem request at a time
// Ports: clk/reset_n (async active-low); PCSrc/PCTarget select next PC on retire;
//        imem_req/imem_addr/imem_gnt request, imem_rvalid/imem_rdata/imem_err response;
//        Instr/instr_valid/instr_ready hand-off with PC, PCPlus4 and decoded op/funct3/funct7b5;
//        fetch_fault is sticky until reset.
module fetch_unit #(
    parameter int XLEN = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            PCSrc,
    input  logic [XLEN-1:0] PCTarget,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [31:0]     imem_rdata,
    input  logic            imem_err,
    output logic [31:0]     Instr,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [XLEN-1:0] PC,
    output logic [XLEN-1:0] PCPlus4,
    output logic [6:0]      op,
    output logic [2:0]      funct3,
    output logic            funct7b5,
    output logic            fetch_fault
);
    typedef enum logic [2:0] {IDLE, REQ, WAIT, HOLD, FAULT} state_t;
    state_t state, state_next;
    logic retire, misaligned, capture;
    assign retire     = state == HOLD && instr_ready;
    assign misaligned = PCSrc && PCTarget[1:0] != 2'b00;
    assign capture    = state == WAIT && imem_rvalid && !imem_err;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            PC    <= RESET_PC;
            Instr <= 32'h0000_0013;
        end else begin
            state <= state_next;
            if (retire && !misaligned) PC <= PCSrc ? PCTarget : PCPlus4;
            if (capture) Instr <= imem_rdata;
        end
    end
    // Responses outside WAIT fall through untouched, so stale rvalid after reset is ignored.
    always_comb begin
        state_next = FAULT;
        case (state)
            IDLE:    state_next = REQ;
            REQ:     state_next = imem_gnt ? WAIT : REQ;
            WAIT:    state_next = !imem_rvalid ? WAIT : imem_err ? FAULT : HOLD;
            HOLD:    state_next = !instr_ready ? HOLD : misaligned ? FAULT : REQ;
            default: state_next = FAULT;
        endcase
    end
    assign imem_req    = state == REQ;
    assign imem_addr   = PC;
    assign instr_valid = state == HOLD;
    assign fetch_fault = state == FAULT;
    assign PCPlus4     = PC + XLEN'(4);
    assign op          = Instr[6:0];
    assign funct3      = Instr[14:12];
    assign funct7b5    = Instr[30];
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: randomized self-checking bench for fetch_unit against a PC/Instr reference model
module tb_fetch_unit;
    logic        clk = 0, reset_n = 0, PCSrc = 0, imem_gnt = 0, imem_rvalid = 0, imem_err = 0, instr_ready = 0;
    logic [31:0] PCTarget = 0, imem_rdata = 0;
    logic        imem_req, instr_valid, funct7b5, fetch_fault;
    logic [31:0] imem_addr, Instr, PC, PCPlus4;
    logic [6:0]  op;
    logic [2:0]  funct3;
    int total = 0, bad = 0;
    logic [31:0] exp_pc, exp_instr;

    fetch_unit dut (
        .clk(clk), .reset_n(reset_n), .PCSrc(PCSrc), .PCTarget(PCTarget),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .imem_err(imem_err),
        .Instr(Instr), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .PC(PC), .PCPlus4(PCPlus4), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .fetch_fault(fetch_fault)
    );

    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset;
        reset_n = 0; PCSrc = 0; PCTarget = 0; imem_gnt = 0; imem_rvalid = 0; imem_err = 0; instr_ready = 0;
        step;
        step;
        total++;
        if ({imem_req, instr_valid, fetch_fault, Instr, PC} !== {3'b000, 32'h13, 32'h0}) begin
            bad++;
            $display("FAIL reset_vals got=%h exp=%h", {imem_req, instr_valid, fetch_fault, Instr, PC}, {3'b000, 32'h13, 32'h0});
        end
        reset_n = 1;
        exp_pc = 0;
        exp_instr = 32'h13;
        total++;
        if (imem_req !== 1'b0) begin
            bad++;
            $display("FAIL idle_req got=%b exp=0", imem_req);
        end
    endtask

    task automatic fetch(input int gd, input int rd, input logic [31:0] data, input logic err);
        int n = 0;
        logic [31:0] p4;
        while (imem_req !== 1'b1 && n < 8) begin
            step;
            n++;
        end
        for (int i = 0; i <= gd; i++) begin
            total++;
            if ({imem_req, imem_addr, instr_valid} !== {1'b1, exp_pc, 1'b0}) begin
                bad++;
                $display("FAIL req_phase got=%h exp=%h", {imem_req, imem_addr, instr_valid}, {1'b1, exp_pc, 1'b0});
            end
            imem_gnt = (i == gd);
            instr_ready = 1'($urandom);
            PCSrc = 1'($urandom);
            step;
        end
        imem_gnt = 0;
        for (int i = 0; i <= rd; i++) begin
            total++;
            if ({imem_req, instr_valid, fetch_fault} !== 3'b000) begin
                bad++;
                $display("FAIL wait_phase got=%b exp=000", {imem_req, instr_valid, fetch_fault});
            end
            imem_rvalid = (i == rd);
            imem_rdata = (i == rd) ? data : $urandom;
            imem_err = (i == rd) ? err : 1'($urandom);
            instr_ready = 1'($urandom);
            step;
        end
        imem_rvalid = 0; imem_err = 0; instr_ready = 0; PCSrc = 0;
        if (err) begin
            total++;
            if ({fetch_fault, instr_valid, imem_req, Instr, PC} !== {3'b100, exp_instr, exp_pc}) begin
                bad++;
                $display("FAIL err_resp got=%h exp=%h", {fetch_fault, instr_valid, imem_req, Instr, PC}, {3'b100, exp_instr, exp_pc});
            end
        end else begin
            exp_instr = data;
            p4 = exp_pc + 32'd4;
            total++;
            if ({instr_valid, fetch_fault, Instr, PC, PCPlus4} !== {2'b10, exp_instr, exp_pc, p4}) begin
                bad++;
                $display("FAIL capture got=%h exp=%h", {instr_valid, fetch_fault, Instr, PC, PCPlus4}, {2'b10, exp_instr, exp_pc, p4});
            end
            total++;
            if ({op, funct3, funct7b5} !== {data[6:0], data[14:12], data[30]}) begin
                bad++;
                $display("FAIL fields got=%h exp=%h", {op, funct3, funct7b5}, {data[6:0], data[14:12], data[30]});
            end
        end
    endtask

    task automatic retire(input int hold, input logic src, input logic [31:0] tgt);
        for (int i = 0; i < hold; i++) begin
            total++;
            if ({instr_valid, Instr, PC} !== {1'b1, exp_instr, exp_pc}) begin
                bad++;
                $display("FAIL hold_stable got=%h exp=%h", {instr_valid, Instr, PC}, {1'b1, exp_instr, exp_pc});
            end
            PCSrc = 1'($urandom);
            PCTarget = $urandom;
            step;
        end
        PCSrc = src; PCTarget = tgt; instr_ready = 1;
        step;
        instr_ready = 0; PCSrc = 0;
        if (src && tgt[1:0] != 2'b00) begin
            total++;
            if ({fetch_fault, instr_valid, imem_req, PC} !== {3'b100, exp_pc}) begin
                bad++;
                $display("FAIL misalign got=%h exp=%h", {fetch_fault, instr_valid, imem_req, PC}, {3'b100, exp_pc});
            end
        end else begin
            exp_pc = src ? tgt : exp_pc + 32'd4;
            total++;
            if ({instr_valid, imem_req, fetch_fault, imem_addr, PC} !== {3'b010, exp_pc, exp_pc}) begin
                bad++;
                $display("FAIL retire got=%h exp=%h", {instr_valid, imem_req, fetch_fault, imem_addr, PC}, {3'b010, exp_pc, exp_pc});
            end
        end
    endtask

    task automatic check_fault_quiet(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            imem_gnt = 1'($urandom); imem_rvalid = 1'($urandom); imem_rdata = $urandom; instr_ready = 1'($urandom);
            step;
            total++;
            if ({fetch_fault, imem_req, instr_valid, Instr, PC} !== {3'b100, exp_instr, exp_pc}) begin
                bad++;
                $display("FAIL fault_sticky got=%h exp=%h", {fetch_fault, imem_req, instr_valid, Instr, PC}, {3'b100, exp_instr, exp_pc});
            end
        end
        imem_gnt = 0; imem_rvalid = 0; instr_ready = 0;
    endtask

    task automatic test_reset;
        apply_reset;
        step;
        total++;
        if ({imem_req, imem_addr} !== {1'b1, 32'h0}) begin
            bad++;
            $display("FAIL first_req got=%h exp=%h", {imem_req, imem_addr}, {1'b1, 32'h0});
        end
        fetch(0, 0, 32'h0050_0093, 0);
        total++;
        if ({op, funct3, funct7b5, PCPlus4} !== {7'h13, 3'h0, 1'b0, 32'h4}) begin
            bad++;
            $display("FAIL first_fields got=%h exp=%h", {op, funct3, funct7b5, PCPlus4}, {7'h13, 3'h0, 1'b0, 32'h4});
        end
    endtask

    task automatic test_sequence;
        retire(0, 0, 32'h0);
        fetch(0, 0, $urandom, 0);
        retire(2, 1, 32'h100);
        fetch(0, 0, $urandom, 0);
        retire(0, 0, 32'h0);
    endtask

    task automatic test_stall;
        fetch(3, 2, $urandom, 0);
        retire(5, 0, 32'h0);
    endtask

    task automatic test_random;
        for (int k = 0; k < 20; k++) begin
            fetch(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), $urandom, 0);
            retire(int'($urandom_range(0, 3)), 1'($urandom), $urandom & 32'hFFFF_FFFC);
        end
    endtask

    task automatic test_wrap_misalign;
        fetch(0, 0, $urandom, 0);
        retire(0, 1, 32'hFFFF_FFFC);
        fetch(1, 0, $urandom, 0);
        retire(1, 0, 32'h0);
        fetch(0, 1, $urandom, 0);
        retire(0, 1, 32'h102);
        check_fault_quiet(5);
    endtask

    task automatic test_err;
        apply_reset;
        fetch(1, 1, $urandom, 1);
        check_fault_quiet(4);
    endtask

    task automatic test_midreset;
        apply_reset;
        fetch(0, 0, $urandom, 0);
        retire(0, 1, 32'h200);
        imem_gnt = 1;
        step;
        imem_gnt = 0;
        #2;
        reset_n = 0;
        #1;
        total++;
        if ({imem_req, instr_valid, fetch_fault, Instr, PC} !== {3'b000, 32'h13, 32'h0}) begin
            bad++;
            $display("FAIL async_reset got=%h exp=%h", {imem_req, instr_valid, fetch_fault, Instr, PC}, {3'b000, 32'h13, 32'h0});
        end
        step;
        reset_n = 1;
        exp_pc = 0;
        exp_instr = 32'h13;
        imem_rvalid = 1;
        imem_rdata = 32'hDEAD_BEEF;
        for (int i = 0; i < 2; i++) begin
            step;
            total++;
            if ({imem_req, instr_valid, imem_addr, Instr} !== {2'b10, 32'h0, 32'h13}) begin
                bad++;
                $display("FAIL stale_resp got=%h exp=%h", {imem_req, instr_valid, imem_addr, Instr}, {2'b10, 32'h0, 32'h13});
            end
        end
        imem_rvalid = 0;
        fetch(0, 0, $urandom, 0);
        retire(0, 0, 32'h0);
    endtask

    initial begin
        test_reset;
        test_sequence;
        test_stall;
        test_random;
        test_wrap_misalign;
        test_err;
        test_midreset;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the main controller/decoder.
- Owns the architectural PC and runs a single-outstanding request/grant/response handshake to instruction memory.
- Registers the returned instruction and presents it, with the decoded op/funct3/funct7b5 fields, to the controller and datapath.
- Consumes the controller's PCSrc together with the datapath's PCTarget to select the next PC.

Parameters:
XLEN, 32, data/address width in bits
RESET_PC, 32'h0000_0000, PC value loaded on reset

Ports:
clk  in  1  rising-edge clock
reset_n  in  1  asynchronous, active-low reset
PCSrc  in  1  take-branch/jump select from controller; sampled only on retire
PCTarget  in  XLEN  branch/jump target from datapath; sampled only on retire
imem_req  out  1  fetch request
imem_addr  out  XLEN  fetch address (equals PC)
imem_gnt  in  1  request accepted
imem_rvalid  in  1  response valid
imem_rdata  in  32  response instruction word
imem_err  in  1  response error, qualified by imem_rvalid
Instr  out  32  registered instruction
instr_valid  out  1  Instr is valid for consumption
instr_ready  in  1  downstream consumes Instr this cycle
PC  out  XLEN  address of Instr
PCPlus4  out  XLEN  PC+4, modulo 2^XLEN
op  out  7  Instr[6:0]
funct3  out  3  Instr[14:12]
funct7b5  out  1  Instr[30]
fetch_fault  out  1  sticky fault flag

Behaviour:
- Reset (reset_n low, asynchronous):
  - PC=RESET_PC; state=IDLE.
  - imem_req=0; instr_valid=0; fetch_fault=0.
  - Instr=32'h0000_0013 (NOP).
  - Reset applies immediately, including mid-transaction.
- FSM states: IDLE, REQ, WAIT, HOLD, FAULT.
- IDLE:
  - Outputs quiet.
  - Moves to REQ unconditionally on the next edge; first imem_req is asserted in the first cycle after reset deassertion.
- REQ:
  - imem_req=1; imem_addr=PC, held stable until imem_gnt.
  - imem_gnt=1 moves to WAIT; imem_req deasserts in the next cycle.
- WAIT:
  - imem_req=0.
  - imem_rvalid & !imem_err: Instr<=imem_rdata, instr_valid<=1, move to HOLD.
  - imem_rvalid & imem_err: move to FAULT, fetch_fault<=1, Instr unchanged.
- imem_rvalid is legal no earlier than the cycle after grant. rvalid in any state other than WAIT is ignored, which covers stale responses after reset.
- HOLD:
  - instr_valid=1; Instr, PC and the fields are held stable.
  - On instr_valid & instr_ready (retire):
    - If PCSrc=0: PC<=PC+4.
    - If PCSrc=1 and PCTarget[1:0]==0: PC<=PCTarget.
    - If PCSrc=1 and PCTarget[1:0]!=0: misaligned; move to FAULT, fetch_fault<=1, PC unchanged.
    - Otherwise instr_valid<=0 and move to REQ.
  - instr_ready while not valid has no effect.
- Latency: minimum 3 cycles per instruction (REQ with same-cycle gnt, WAIT with rvalid the next cycle, HOLD with ready).
- FAULT:
  - imem_req=0; instr_valid=0; fetch_fault=1.
  - Left only by reset.
- Arithmetic:
  - PCPlus4 is combinational PC+4, truncated to XLEN; 0xFFFF_FFFC wraps to 0x0000_0000.
  - op, funct3 and funct7b5 are combinational slices of the Instr register.
  - Register enables only; no gated clocks.

Test Plan:
- Reset release, memory grants immediately and responds 1 cycle later with 0x00500093 -> imem_addr=0x0 in cycle 1; instr_valid high in cycle 3; op=0x13, funct3=0, funct7b5=0; PCPlus4=0x4.
- Retire with PCSrc=0, then with PCSrc=1 and PCTarget=0x100 -> next imem_addr=0x4, then 0x100; instr_valid low for exactly the REQ and WAIT cycles.
- Grant delayed 3 cycles and rvalid delayed 2 cycles -> imem_req held and imem_addr stable throughout; one Instr captured; instr_ready held low for 5 cycles keeps Instr/PC unchanged.
- PC=0xFFFF_FFFC, retire with PCSrc=0 -> PC=0x0; PCTarget=0x102 with PCSrc=1 -> fetch_fault=1, PC stays, no further imem_req; a later imem_err response path also sets the fault.
- reset_n pulsed low during WAIT, with a stale rvalid arriving after release -> outputs return to reset values asynchronously; the stale response is ignored; the fetch restarts at RESET_PC.
